// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the iob FIFO family: width/ratio constants, log2 and
// parameter legality checks evaluated at elaboration time.
package iob_fifo_pkg;

  function automatic int iob_log2(input int x);
    int r;
    r = 0;
    while ((1 << r) < x) r++;
    return r;
  endfunction

  function automatic int iob_min_w(input int w_data_w, input int r_data_w);
    return (w_data_w < r_data_w) ? w_data_w : r_data_w;
  endfunction

  function automatic int iob_wr(input int w_data_w, input int r_data_w);
    return w_data_w / iob_min_w(w_data_w, r_data_w);
  endfunction

  function automatic int iob_rr(input int w_data_w, input int r_data_w);
    return r_data_w / iob_min_w(w_data_w, r_data_w);
  endfunction

  function automatic int iob_level_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit iob_is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  function automatic bit iob_params_ok(input int w_data_w, input int r_data_w,
                                       input int addr_w, input int afull_th,
                                       input int aempty_th);
    int mn, mx;
    mn = iob_min_w(w_data_w, r_data_w);
    mx = (w_data_w > r_data_w) ? w_data_w : r_data_w;
    if (mn <= 0 || addr_w <= 0) return 1'b0;
    if ((mx % mn) != 0) return 1'b0;
    if (!iob_is_pow2(mx / mn)) return 1'b0;
    if (addr_w < iob_log2(mx / mn)) return 1'b0;
    if (afull_th < 0 || afull_th > (1 << addr_w)) return 1'b0;
    if (aempty_th < 0 || aempty_th > (1 << addr_w)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/iob_fifo_sync_asym_ram.sv
// Single-clock asymmetric 2-port RAM: storage in MIN_W-bit units, each port
// moves an aligned group of units; read port is registered.
module iob_ram_2p_asym
  import iob_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int MIN_W = iob_min_w(W_DATA_W, R_DATA_W);
  localparam int WR    = iob_wr(W_DATA_W, R_DATA_W);
  localparam int RR    = iob_rr(W_DATA_W, R_DATA_W);

  logic [MIN_W-1:0] mem [2**ADDR_W];

  // Addresses are group-aligned, so addr + i never carries out of ADDR_W bits.
  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < WR; i++) begin
        mem[w_addr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (r_en) begin
      for (int j = 0; j < RR; j++) begin
        r_data[j*MIN_W +: MIN_W] <= mem[r_addr + ADDR_W'(j)];
      end
    end
  end

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Single-clock width-converting FIFO. Requests are level-sensitive: a write
// (read) takes effect on the edge where w_en (r_en) is high and w_full (r_empty) is low.
module iob_fifo_sync_asym
  import iob_fifo_pkg::*;
#(
  parameter int W_DATA_W  = 32,
  parameter int R_DATA_W  = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  output logic                w_afull,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic                r_aempty,
  output logic [ADDR_W:0]     level,
  output logic                w_ovf,
  output logic                r_udf
);

  localparam int LVL_W = iob_level_w(ADDR_W);
  localparam int WR    = iob_wr(W_DATA_W, R_DATA_W);
  localparam int RR    = iob_rr(W_DATA_W, R_DATA_W);

  localparam logic [LVL_W-1:0] WR_L      = LVL_W'(WR);
  localparam logic [LVL_W-1:0] RR_L      = LVL_W'(RR);
  localparam logic [LVL_W-1:0] FULL_AT   = LVL_W'((2**ADDR_W) - WR);
  localparam logic [LVL_W-1:0] AFULL_L   = LVL_W'(AFULL_TH);
  localparam logic [LVL_W-1:0] AEMPTY_L  = LVL_W'(AEMPTY_TH);

  if (!iob_params_ok(W_DATA_W, R_DATA_W, ADDR_W, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("iob_fifo_sync_asym: illegal width ratio, ADDR_W or threshold");
  end

  logic [LVL_W-1:0] w_ptr, r_ptr;
  logic             we, re;

  // Flags depend only on registered pointers; no path from w_en/r_en to outputs.
  assign level    = w_ptr - r_ptr;
  assign w_full   = level > FULL_AT;
  assign r_empty  = level < RR_L;
  assign w_afull  = level >= AFULL_L;
  assign r_aempty = level <= AEMPTY_L;

  assign we = w_en & ~w_full;
  assign re = r_en & ~r_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      w_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (we) w_ptr <= w_ptr + WR_L;
      if (re) r_ptr <= r_ptr + RR_L;
      w_ovf <= w_en & w_full;
      r_udf <= r_en & r_empty;
    end
  end

  iob_ram_2p_asym #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (we),
    .w_addr (w_ptr[ADDR_W-1:0]),
    .w_data (w_data),
    .r_en   (re),
    .r_addr (r_ptr[ADDR_W-1:0]),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: three configurations (32->8, 8->32, 8->8)
// checked against a queue of expected read words.
module tb_iob_fifo_sync_asym;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // a: 32 -> 8
  logic        a_w_en = 0, a_r_en = 0;
  logic [31:0] a_w_data = 0;
  logic [7:0]  a_r_data;
  logic        a_w_full, a_w_afull, a_r_empty, a_r_aempty, a_w_ovf, a_r_udf;
  logic [4:0]  a_level;
  // b: 8 -> 32
  logic        b_w_en = 0, b_r_en = 0;
  logic [7:0]  b_w_data = 0;
  logic [31:0] b_r_data;
  logic        b_w_full, b_w_afull, b_r_empty, b_r_aempty, b_w_ovf, b_r_udf;
  logic [4:0]  b_level;
  // c: 8 -> 8
  logic        c_w_en = 0, c_r_en = 0;
  logic [7:0]  c_w_data = 0;
  logic [7:0]  c_r_data;
  logic        c_w_full, c_w_afull, c_r_empty, c_r_aempty, c_w_ovf, c_r_udf;
  logic [4:0]  c_level;

  iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)) u_a (
    .clk(clk), .rst(rst), .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full), .w_afull(a_w_afull),
    .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty), .r_aempty(a_r_aempty), .level(a_level),
    .w_ovf(a_w_ovf), .r_udf(a_r_udf));

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)) u_b (
    .clk(clk), .rst(rst), .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full), .w_afull(b_w_afull),
    .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .r_aempty(b_r_aempty), .level(b_level),
    .w_ovf(b_w_ovf), .r_udf(b_r_udf));

  iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)) u_c (
    .clk(clk), .rst(rst), .w_en(c_w_en), .w_data(c_w_data), .w_full(c_w_full), .w_afull(c_w_afull),
    .r_en(c_r_en), .r_data(c_r_data), .r_empty(c_r_empty), .r_aempty(c_r_aempty), .level(c_level),
    .w_ovf(c_w_ovf), .r_udf(c_r_udf));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (a_level !== 5'd0 || a_r_empty !== 1'b1 || a_w_full !== 1'b0 || a_r_aempty !== 1'b1 ||
        a_w_afull !== 1'b0 || a_r_data !== 8'h0 || a_w_ovf !== 1'b0 || a_r_udf !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: level=%0d empty=%b full=%b aempty=%b afull=%b rdata=%h ovf=%b udf=%b, want 0 1 0 1 0 00 0 0",
               a_level, a_r_empty, a_w_full, a_r_aempty, a_w_afull, a_r_data, a_w_ovf, a_r_udf);
    end
    total++;
    if (b_level !== 5'd0 || b_r_empty !== 1'b1 || b_r_data !== 32'h0 || c_level !== 5'd0 || c_r_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_bc: b_level=%0d b_empty=%b b_rdata=%h c_level=%0d c_empty=%b, want 0 1 0 0 1",
               b_level, b_r_empty, b_r_data, c_level, c_r_empty);
    end
    rst = 1'b0;
    tick();
  endtask

  // Read one byte from instance a and compare against the queue head.
  task automatic read_a(input string name);
    logic [31:0] e;
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got %h with empty expected queue", name, a_r_data);
    end else begin
      e = exp_q.pop_front();
      if ({24'h0, a_r_data} !== e) begin
        bad++;
        $display("FAIL %s: r_data=%h want %h", name, a_r_data, e[7:0]);
      end
    end
  endtask

  task automatic write_a(input logic [31:0] d);
    a_w_en = 1'b1;
    a_w_data = d;
    for (int k = 0; k < 4; k++) exp_q.push_back({24'h0, d[k*8 +: 8]});
    tick();
    a_w_en = 1'b0;
  endtask

  task automatic test_wide_write();
    write_a(32'h44332211);
    total++;
    if (a_level !== 5'd4 || a_r_empty !== 1'b0) begin
      bad++;
      $display("FAIL wide_write_level: level=%0d empty=%b want 4 0", a_level, a_r_empty);
    end
    for (int i = 0; i < 4; i++) begin
      read_a("wide_write_data");
      total++;
      if (a_level !== 5'(3 - i)) begin
        bad++;
        $display("FAIL wide_write_step: level=%0d want %0d", a_level, 3 - i);
      end
    end
    total++;
    if (a_r_empty !== 1'b1) begin
      bad++;
      $display("FAIL wide_write_empty: r_empty=%b want 1", a_r_empty);
    end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 4; i++) write_a($urandom());
    total++;
    if (a_level !== 5'd16 || a_w_full !== 1'b1 || a_w_afull !== 1'b1) begin
      bad++;
      $display("FAIL full_level: level=%0d full=%b afull=%b want 16 1 1", a_level, a_w_full, a_w_afull);
    end
    a_w_en = 1'b1;
    a_w_data = 32'hDEADBEEF;
    tick();
    a_w_en = 1'b0;
    total++;
    if (a_w_ovf !== 1'b1 || a_level !== 5'd16) begin
      bad++;
      $display("FAIL ovf_pulse: ovf=%b level=%0d want 1 16", a_w_ovf, a_level);
    end
    tick();
    total++;
    if (a_w_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_once: ovf=%b want 0", a_w_ovf);
    end
    read_a("full_read1");
    total++;
    if (a_w_full !== 1'b1 || a_level !== 5'd15) begin
      bad++;
      $display("FAIL full_after_1: full=%b level=%0d want 1 15", a_w_full, a_level);
    end
    for (int i = 0; i < 3; i++) read_a("full_read3");
    total++;
    if (a_w_full !== 1'b0 || a_level !== 5'd12) begin
      bad++;
      $display("FAIL full_after_4: full=%b level=%0d want 0 12", a_w_full, a_level);
    end
    for (int i = 0; i < 12; i++) read_a("full_drain");
  endtask

  task automatic test_narrow_write();
    logic [7:0] seq [4];
    seq[0] = 8'hAA; seq[1] = 8'hBB; seq[2] = 8'hCC; seq[3] = 8'hDD;
    for (int i = 0; i < 3; i++) begin
      b_w_en = 1'b1;
      b_w_data = seq[i];
      tick();
    end
    b_w_en = 1'b0;
    total++;
    if (b_r_empty !== 1'b1 || b_level !== 5'd3) begin
      bad++;
      $display("FAIL narrow_partial: empty=%b level=%0d want 1 3", b_r_empty, b_level);
    end
    b_w_en = 1'b1;
    b_w_data = seq[3];
    exp_q.push_back(32'hDDCCBBAA);
    tick();
    b_w_en = 1'b0;
    total++;
    if (b_r_empty !== 1'b0 || b_level !== 5'd4) begin
      bad++;
      $display("FAIL narrow_ready: empty=%b level=%0d want 0 4", b_r_empty, b_level);
    end
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    total++;
    if (exp_q.size() == 0 || b_r_data !== exp_q[0] || b_level !== 5'd0) begin
      bad++;
      $display("FAIL narrow_data: r_data=%h level=%0d want ddccbbaa 0", b_r_data, b_level);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic write_c(input logic [7:0] d);
    c_w_en = 1'b1;
    c_w_data = d;
    exp_q.push_back({24'h0, d});
    tick();
    c_w_en = 1'b0;
  endtask

  task automatic read_c(input string name);
    logic [31:0] e;
    c_r_en = 1'b1;
    tick();
    c_r_en = 1'b0;
    total++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    if ({24'h0, c_r_data} !== e) begin
      bad++;
      $display("FAIL %s: r_data=%h want %h", name, c_r_data, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int errs;
    for (int i = 0; i < 15; i++) write_c(8'($urandom_range(0, 255)));
    total++;
    if (c_level !== 5'd15) begin
      bad++;
      $display("FAIL b2b_fill: level=%0d want 15", c_level);
    end
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      c_w_en = 1'b1;
      c_r_en = 1'b1;
      c_w_data = 8'($urandom_range(0, 255));
      exp_q.push_back({24'h0, c_w_data});
      tick();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      total++;
      if ({24'h0, c_r_data} !== e || c_level !== 5'd15 || c_w_afull !== 1'b1 || c_r_aempty !== 1'b0) begin
        bad++;
        errs++;
        if (errs < 5)
          $display("FAIL b2b_cycle%0d: r_data=%h level=%0d afull=%b aempty=%b want %h 15 1 0",
                   i, c_r_data, c_level, c_w_afull, c_r_aempty, e[7:0]);
      end
    end
    c_w_en = 1'b0;
    c_r_en = 1'b0;
    for (int i = 0; i < 15; i++) read_c("b2b_drain");
  endtask

  task automatic test_thresholds();
    logic [7:0] held;
    held = c_r_data;
    c_r_en = 1'b1;
    tick();
    c_r_en = 1'b0;
    total++;
    if (c_r_udf !== 1'b1 || c_r_data !== held) begin
      bad++;
      $display("FAIL udf_pulse: udf=%b r_data=%h want 1 %h", c_r_udf, c_r_data, held);
    end
    tick();
    total++;
    if (c_r_udf !== 1'b0) begin
      bad++;
      $display("FAIL udf_once: udf=%b want 0", c_r_udf);
    end
    for (int lv = 1; lv <= 12; lv++) begin
      write_c(8'(lv));
      if (lv == 4 || lv == 5) begin
        total++;
        if (c_r_aempty !== (lv == 4)) begin
          bad++;
          $display("FAIL aempty_lv%0d: r_aempty=%b want %b", lv, c_r_aempty, lv == 4);
        end
      end
      if (lv == 11 || lv == 12) begin
        total++;
        if (c_w_afull !== (lv == 12)) begin
          bad++;
          $display("FAIL afull_lv%0d: w_afull=%b want %b", lv, c_w_afull, lv == 12);
        end
      end
    end
    for (int i = 0; i < 12; i++) read_c("thr_drain");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 9; i++) write_c(8'h80 | 8'(i));
    read_c("rst_pre_read");
    write_c(8'h90);
    total++;
    if (c_level !== 5'd9 || c_r_data === 8'h00) begin
      bad++;
      $display("FAIL rst_setup: level=%0d r_data=%h want 9 nonzero", c_level, c_r_data);
    end
    c_w_en = 1'b1;
    c_r_en = 1'b1;
    c_w_data = 8'h33;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (c_level !== 5'd0 || c_r_empty !== 1'b1 || c_r_data !== 8'h00) begin
      bad++;
      $display("FAIL async_rst: level=%0d empty=%b r_data=%h want 0 1 00", c_level, c_r_empty, c_r_data);
    end
    c_w_en = 1'b0;
    c_r_en = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    write_c(8'h5A);
    read_c("rst_roundtrip");
    total++;
    if (c_r_empty !== 1'b1 || c_level !== 5'd0) begin
      bad++;
      $display("FAIL rst_roundtrip_level: empty=%b level=%0d want 1 0", c_r_empty, c_level);
    end
  endtask

  initial begin
    test_reset();
    test_wide_write();
    test_full_ovf();
    test_narrow_write();
    test_back_to_back();
    test_thresholds();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
